// File: rtl/lsu1_c.sv
// lsu1_c: first load/store stage; issues one data-bus transaction per memory op (ports: clk, rst, flush, ex_ls_*, ex_rt_data, ex_has_exception, data_* bus, lsu1_stall_req, lsu1_load_valid, lsu1_load_data)
module lsu1_c #(
  parameter bit STORE_WAIT_DATA_OK = 1'b1
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        flush,
  input  logic        ex_ls_ena,
  input  logic [3:0]  ex_ls_sel,
  input  logic [31:0] ex_ls_addr,
  input  logic [31:0] ex_rt_data,
  input  logic        ex_has_exception,
  output logic        data_req,
  output logic        data_wr,
  output logic [1:0]  data_size,
  output logic [31:0] data_addr,
  output logic [3:0]  data_wstrb,
  output logic [31:0] data_wdata,
  input  logic        data_addr_ok,
  input  logic        data_data_ok,
  input  logic [31:0] data_rdata,
  output logic        lsu1_stall_req,
  output logic        lsu1_load_valid,
  output logic [31:0] lsu1_load_data
);
  typedef enum logic [2:0] {IDLE, REQ, WAIT, DONE, DRAIN} state_t;
  state_t state, state_n;
  logic [3:0] sel_r;
  logic in_valid, st_fast, ld_cap;
  logic [3:0] wstrb_n;
  logic [31:0] wdata_n, ld;
  logic [7:0] rb;
  logic [15:0] rh;
  assign in_valid = ex_ls_ena & ~ex_has_exception & ~flush;
  assign st_fast = sel_r[3] & ~STORE_WAIT_DATA_OK;
  assign data_wr = sel_r[3];
  assign data_req = state == REQ;
  assign lsu1_stall_req = (state == IDLE & in_valid) | state == REQ | state == WAIT | state == DRAIN;
  assign lsu1_load_valid = state == DONE & ~sel_r[3] & ~flush;
  assign ld_cap = ((state == REQ & data_addr_ok) | state == WAIT) & data_data_ok & ~sel_r[3];
  always_comb begin
    wstrb_n = ~ex_ls_sel[3] ? 4'h0 : ex_ls_sel[1] ? 4'hf : ex_ls_sel[0] ? (ex_ls_addr[1] ? 4'hc : 4'h3) : 4'b0001 << ex_ls_addr[1:0];
    wdata_n = ex_ls_sel[1] ? ex_rt_data : ex_ls_sel[0] ? {2{ex_rt_data[15:0]}} : {4{ex_rt_data[7:0]}};
    rb = data_rdata[{data_addr[1:0], 3'b000} +: 8];
    rh = data_addr[1] ? data_rdata[31:16] : data_rdata[15:0];
    ld = sel_r[2] ? data_rdata : sel_r[1] ? {{16{rh[15] & ~sel_r[0]}}, rh} : {{24{rb[7] & ~sel_r[0]}}, rb};
    state_n = state == IDLE ? (in_valid ? REQ : IDLE)
            : state == REQ ? (data_addr_ok ? (flush ? (data_data_ok ? IDLE : DRAIN) : (data_data_ok | st_fast) ? DONE : WAIT) : flush ? IDLE : REQ)
            : state == WAIT ? (data_data_ok ? (flush ? IDLE : DONE) : flush ? DRAIN : WAIT)
            : state == DRAIN ? (data_data_ok ? IDLE : DRAIN) : IDLE;
  end
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= IDLE;
      sel_r <= '0;
      data_size <= '0;
      data_addr <= '0;
      data_wstrb <= '0;
      data_wdata <= '0;
      lsu1_load_data <= '0;
    end else begin
      state <= state_n;
      if (state == IDLE & in_valid) begin
        sel_r <= ex_ls_sel;
        data_size <= ex_ls_sel[3] ? ex_ls_sel[1:0] : ex_ls_sel[2:1];
        data_addr <= ex_ls_addr;
        data_wstrb <= wstrb_n;
        data_wdata <= wdata_n;
      end
      if (ld_cap) lsu1_load_data <= ld;
    end
  end
endmodule

// File: tb/tb_lsu1_c.sv
// tb_lsu1_c: scoreboard bench for lsu1_c driving a scripted data-bus responder
module tb_lsu1_c;
  logic clk = 0, rst = 1, flush = 0, ex_ls_ena = 0, ex_has_exception = 0;
  logic [3:0] ex_ls_sel = 0;
  logic [31:0] ex_ls_addr = 0, ex_rt_data = 0, data_rdata = 0;
  logic data_addr_ok = 0, data_data_ok = 0;
  logic data_req, data_wr, lsu1_stall_req, lsu1_load_valid;
  logic [1:0] data_size;
  logic [31:0] data_addr, data_wdata, lsu1_load_data;
  logic [3:0] data_wstrb;
  int total = 0, bad = 0;
  logic [31:0] sb_q[$];
  lsu1_c dut (
    .clk(clk), .rst(rst), .flush(flush), .ex_ls_ena(ex_ls_ena), .ex_ls_sel(ex_ls_sel),
    .ex_ls_addr(ex_ls_addr), .ex_rt_data(ex_rt_data), .ex_has_exception(ex_has_exception),
    .data_req(data_req), .data_wr(data_wr), .data_size(data_size), .data_addr(data_addr),
    .data_wstrb(data_wstrb), .data_wdata(data_wdata), .data_addr_ok(data_addr_ok),
    .data_data_ok(data_data_ok), .data_rdata(data_rdata), .lsu1_stall_req(lsu1_stall_req),
    .lsu1_load_valid(lsu1_load_valid), .lsu1_load_data(lsu1_load_data)
  );
  always #5 clk = ~clk;
  task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h want %h", tag, act, exp);
    end
  endtask
  function automatic logic [1:0] m_size(input logic [3:0] sel);
    case (sel)
      4'h0, 4'h1, 4'h8: return 2'd0;
      4'h2, 4'h3, 4'h9: return 2'd1;
      default: return 2'd2;
    endcase
  endfunction
  function automatic logic [31:0] m_load(input logic [3:0] sel, input logic [31:0] addr, input logic [31:0] rd);
    logic [31:0] b, h;
    b = rd >> (8 * addr[1:0]);
    h = rd >> (16 * addr[1]);
    case (sel)
      4'h0: return {{24{b[7]}}, b[7:0]};
      4'h1: return {24'h0, b[7:0]};
      4'h2: return {{16{h[15]}}, h[15:0]};
      4'h3: return {16'h0, h[15:0]};
      default: return rd;
    endcase
  endfunction
  function automatic logic [3:0] m_strb(input logic [3:0] sel, input logic [31:0] addr);
    case (sel)
      4'h8: return 4'b0001 << addr[1:0];
      4'h9: return addr[1] ? 4'b1100 : 4'b0011;
      4'ha: return 4'b1111;
      default: return 4'b0000;
    endcase
  endfunction
  function automatic logic [31:0] m_wdata(input logic [3:0] sel, input logic [31:0] rt);
    case (sel)
      4'h8: return {4{rt[7:0]}};
      4'h9: return {2{rt[15:0]}};
      default: return rt;
    endcase
  endfunction
  initial forever begin
    @(negedge clk);
    #2;
    if (lsu1_load_valid) begin
      if (sb_q.size() == 0) chk("lv_unexpected", 32'd1, 32'd0);
      else chk("load_data", lsu1_load_data, sb_q.pop_front());
    end
  end
  task automatic run_op(input logic [3:0] sel, input logic [31:0] addr, input logic [31:0] rt, input logic [31:0] rd,
                        input int a, input int d, input logic [31:0] ld_exp, input logic [3:0] strb_exp, input logic [31:0] wd_exp);
    @(negedge clk);
    ex_ls_ena = 1; ex_ls_sel = sel; ex_ls_addr = addr; ex_rt_data = rt;
    #1 chk("stall_accept", lsu1_stall_req, 1);
    if (!sel[3]) sb_q.push_back(ld_exp);
    for (int i = 0; i <= a; i++) begin
      @(negedge clk);
      ex_ls_ena = 0; ex_ls_sel = 0; ex_ls_addr = 0; ex_rt_data = 0;
      if (i == a) begin
        data_addr_ok = 1;
        data_data_ok = d == 0;
        data_rdata = rd;
      end
      #1;
      chk("req", data_req, 1);
      chk("stall_req", lsu1_stall_req, 1);
      chk("addr", data_addr, addr);
      chk("wr", data_wr, sel[3]);
      chk("size", data_size, m_size(sel));
      chk("wstrb", data_wstrb, strb_exp);
      if (sel[3]) chk("wdata", data_wdata, wd_exp);
    end
    if (d > 0) begin
      for (int i = 1; i <= d; i++) begin
        @(negedge clk);
        data_addr_ok = 0;
        data_data_ok = i == d;
        #1;
        chk("wait_req", data_req, 0);
        chk("wait_stall", lsu1_stall_req, 1);
      end
    end
    @(negedge clk);
    data_addr_ok = 0; data_data_ok = 0; data_rdata = 32'h5a5a_a5a5;
    #1;
    chk("done_stall", lsu1_stall_req, 0);
    chk("done_lv", lsu1_load_valid, !sel[3]);
  endtask
  initial begin
    logic [3:0] sels [8] = '{4'h0, 4'h1, 4'h2, 4'h3, 4'h4, 4'h8, 4'h9, 4'ha};
    repeat (2) @(negedge clk);
    chk("reset_outs", {data_req, data_wr, data_size, data_addr, data_wstrb, data_wdata, lsu1_stall_req, lsu1_load_valid, lsu1_load_data}, 0);
    rst = 0;
    run_op(4'h4, 32'h1000, 0, 32'hdeadbeef, 1, 2, 32'hdeadbeef, 4'h0, 0);
    run_op(4'h0, 32'h1003, 0, 32'h80ffffff, 0, 1, 32'hffffff80, 4'h0, 0);
    run_op(4'h1, 32'h1003, 0, 32'h80ffffff, 2, 0, 32'h00000080, 4'h0, 0);
    run_op(4'h3, 32'h1002, 0, 32'h80ffffff, 0, 3, 32'h000080ff, 4'h0, 0);
    run_op(4'h8, 32'h2001, 32'h12345678, 0, 0, 1, 0, 4'b0010, 32'h78787878);
    run_op(4'h9, 32'h2002, 32'h12345678, 0, 1, 1, 0, 4'b1100, 32'h56785678);
    run_op(4'ha, 32'h2004, 32'hcafebabe, 0, 5, 0, 0, 4'b1111, 32'hcafebabe);
    run_op(4'h2, 32'h3000, 0, 32'h1234_8001, 0, 0, 32'hffff8001, 4'h0, 0);
    for (int n = 0; n < 12; n++) begin
      logic [3:0] s;
      logic [31:0] ad, rt, rd;
      s = sels[$urandom_range(0, 7)];
      ad = $urandom & ~((32'd1 << m_size(s)) - 1);
      rt = $urandom; rd = $urandom;
      run_op(s, ad, rt, rd, $urandom_range(0, 3), $urandom_range(0, 3), m_load(s, ad, rd), m_strb(s, ad), m_wdata(s, rt));
    end
    @(negedge clk);
    ex_ls_ena = 1; ex_ls_sel = 4'h4; ex_ls_addr = 32'h4000; ex_has_exception = 1;
    #1 chk("exc_stall", lsu1_stall_req, 0);
    @(negedge clk);
    ex_ls_ena = 0; ex_has_exception = 0;
    #1 chk("exc_req", data_req, 0);
    @(negedge clk);
    ex_ls_ena = 1; ex_ls_sel = 4'h4; ex_ls_addr = 32'h5000;
    @(negedge clk);
    ex_ls_ena = 0; flush = 1;
    #1 chk("fr_req_before", data_req, 1);
    @(negedge clk);
    flush = 0;
    #1 chk("fr_req_after", data_req, 0);
    chk("fr_stall_after", lsu1_stall_req, 0);
    @(negedge clk);
    ex_ls_ena = 1; ex_ls_sel = 4'h4; ex_ls_addr = 32'h6000;
    @(negedge clk);
    ex_ls_ena = 0; data_addr_ok = 1;
    @(negedge clk);
    data_addr_ok = 0; flush = 1;
    #1 chk("fw_stall", lsu1_stall_req, 1);
    @(negedge clk);
    flush = 0;
    #1 chk("drain_stall", lsu1_stall_req, 1);
    chk("drain_req", data_req, 0);
    @(negedge clk);
    data_data_ok = 1; data_rdata = 32'h11111111;
    #1 chk("drain_dok_stall", lsu1_stall_req, 1);
    @(negedge clk);
    data_data_ok = 0;
    #1 chk("drain_end_stall", lsu1_stall_req, 0);
    chk("drain_end_lv", lsu1_load_valid, 0);
    @(negedge clk);
    ex_ls_ena = 1; ex_ls_sel = 4'h8; ex_ls_addr = 32'h7003; ex_rt_data = 32'haabbccdd;
    @(negedge clk);
    ex_ls_ena = 0; data_addr_ok = 1;
    @(negedge clk);
    data_addr_ok = 0;
    #1 chk("wait_pre_rst", lsu1_stall_req, 1);
    rst = 1;
    #1 chk("rst_outs", {data_req, data_wr, data_size, data_addr, data_wstrb, data_wdata, lsu1_stall_req, lsu1_load_valid, lsu1_load_data}, 0);
    @(negedge clk);
    rst = 0;
    @(negedge clk);
    chk("sb_left", sb_q.size(), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
